// File: rtl/conv_window_accumulator.sv
// Sums one K*K window of signed products plus a bias, saturates or truncates to OUT_W,
// and holds the result on a valid/ready port until the consumer takes it.
module conv_window_accumulator #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int ACC_W  = 40,
  parameter int MAX_K  = 7,
  parameter int SAT_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               kernel_size,
  input  logic signed [OUT_W-1:0]  bias,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MAX_K * MAX_K + 1);
  localparam int HI_W  = ACC_W - OUT_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        target;
  logic [CNT_W-1:0]        target_in;
  logic                    beat;
  logic                    last_beat;

  // Zero edge means a 1x1 window; oversize edges clamp to MAX_K.
  function automatic logic [CNT_W-1:0] window_len(input logic [7:0] ks);
    logic [7:0]  k;
    logic [15:0] sq;
    if (ks == 8'd0)
      k = 8'd1;
    else if (ks > 8'(MAX_K))
      k = 8'(MAX_K);
    else
      k = ks;
    sq = 16'(k) * 16'(k);
    return CNT_W'(sq);
  endfunction

  // Returns {flag, value}; flag marks a result that did not fit OUT_W.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic [HI_W-1:0] hi;
    logic            fits;
    hi   = a[ACC_W-1:OUT_W-1];
    fits = (&hi) | ~(|hi);
    if (fits)
      return {1'b0, a[OUT_W-1:0]};
    else if (SAT_EN == 0)
      return {1'b1, a[OUT_W-1:0]};
    else if (a[ACC_W-1])
      return {2'b11, {(OUT_W-1){1'b0}}};
    else
      return {2'b10, {(OUT_W-1){1'b1}}};
  endfunction

  assign in_ready  = !rst && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign beat      = in_valid && in_ready;

  always_comb begin
    target_in = window_len(kernel_size);
    if (state == IDLE)
      acc_nxt = ACC_W'(bias) + ACC_W'(in_data);
    else
      acc_nxt = acc + ACC_W'(in_data);
    if (state == IDLE)
      last_beat = beat && (target_in == CNT_W'(1));
    else
      last_beat = beat && (state == ACCUM) && ((count + CNT_W'(1)) == target);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      target   <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (beat) begin
          target <= target_in;
          acc    <= acc_nxt;
          count  <= CNT_W'(1);
          state  <= last_beat ? HOLD : ACCUM;
        end
        ACCUM: if (beat) begin
          acc   <= acc_nxt;
          count <= count + CNT_W'(1);
          if (last_beat)
            state <= HOLD;
        end
        HOLD: if (out_ready)
          state <= IDLE;
        default: state <= IDLE;
      endcase
      // Output register captures the final sum as the window closes.
      if (last_beat)
        {out_sat, out_data} <= sat_fn(acc_nxt);
    end
  end

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Directed bench for conv_window_accumulator: window sums, bubbles, backpressure,
// saturation, mid-window reset and kernel-size edge cases.
module tb_conv_window_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         kernel_size;
  logic signed [31:0] bias;
  logic signed [31:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sat;
  logic               busy;

  int errors = 0;
  int checks = 0;

  conv_window_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .kernel_size (kernel_size),
    .bias        (bias),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sat     (out_sat),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int d);
    in_valid = 1'b1;
    in_data  = 16'(d);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; kernel_size = 8'd2;
    bias = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: K=2 back-to-back
    kernel_size = 8'd2;
    beat(3); beat(2); beat(1);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    beat(-2);
    in_valid = 1'b0;
    chk("t1_valid",    32'(out_valid), 32'd1);
    chk("t1_data",     out_data,       32'd4);
    chk("t1_sat",      32'(out_sat),   32'd0);
    chk("t1_in_ready", 32'(in_ready),  32'd0);
    step();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_busy_drop",  32'(busy),      32'd0);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);

    // Test 2: K=3 with bubbles and mid-window kernel_size change
    kernel_size = 8'd3;
    beat(3);
    kernel_size = 8'd2;
    beat(-5); beat(1); beat(-2);
    idle(2);
    chk("t2_busy_bubble",  32'(busy),      32'd1);
    chk("t2_valid_bubble", 32'(out_valid), 32'd0);
    beat(3); beat(2); beat(-5); beat(1);
    chk("t2_no_valid_8", 32'(out_valid), 32'd0);
    beat(-2);
    in_valid = 1'b0;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data",  out_data,       32'hFFFF_FFFC);
    chk("t2_sat",   32'(out_sat),   32'd0);
    step();

    // Test 3: backpressure
    out_ready = 1'b0;
    kernel_size = 8'd2;
    beat(1); beat(1); beat(1); beat(1);
    in_data = 16'd99;
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data",  out_data,       32'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
      chk("t3_hold_valid",    32'(out_valid), 32'd1);
      chk("t3_hold_data",     out_data,       32'd4);
      chk("t3_hold_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("t3_release", 32'(out_valid), 32'd0);
    chk("t3_release_busy", 32'(busy), 32'd0);
    kernel_size = 8'd1;
    beat(7);
    in_valid = 1'b0;
    chk("t3_k1_valid", 32'(out_valid), 32'd1);
    chk("t3_k1_data",  out_data,       32'd7);
    step();

    // Test 4: saturation both directions
    kernel_size = 8'd1;
    bias = 32'h7FFF_FFF0;
    beat(32'h7FFF);
    in_valid = 1'b0;
    chk("t4_pos_data", out_data,     32'h7FFF_FFFF);
    chk("t4_pos_sat",  32'(out_sat), 32'd1);
    step();
    bias = 32'h8000_0000;
    beat(-1);
    in_valid = 1'b0;
    chk("t4_neg_data", out_data,     32'h8000_0000);
    chk("t4_neg_sat",  32'(out_sat), 32'd1);
    step();
    bias = '0;

    // Test 5: reset mid-window
    kernel_size = 8'd2;
    beat(5); beat(5);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("t5_rst_busy",  32'(busy),      32'd0);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_after_valid", 32'(out_valid), 32'd0);
    chk("t5_after_busy",  32'(busy),      32'd0);
    beat(1); beat(1); beat(1); beat(1);
    in_valid = 1'b0;
    chk("t5_data", out_data, 32'd4);
    step();

    // Test 6: kernel_size edges
    kernel_size = 8'd0;
    bias = 32'd1;
    beat(9);
    in_valid = 1'b0;
    chk("t6_k0_valid", 32'(out_valid), 32'd1);
    chk("t6_k0_data",  out_data,       32'd10);
    step();
    bias = '0;
    kernel_size = 8'd200;
    for (int i = 0; i < 48; i++) beat(1);
    chk("t6_k200_not_yet", 32'(out_valid), 32'd0);
    beat(1);
    in_valid = 1'b0;
    chk("t6_k200_valid", 32'(out_valid), 32'd1);
    chk("t6_k200_data",  out_data,       32'd49);
    step();
    chk("t6_final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
